// File: rtl/time_pkg.sv
// Shared time-field widths, packed 24h time layout, set-path FSM states and error codes.
// Pure definitions: no logic, no latency, no handshake.
package time_pkg;

  localparam int HH_W = 5;
  localparam int MM_W = 6;
  localparam int SS_W = 6;
  localparam int TIME_W = HH_W + MM_W + SS_W;

  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MM_W-1:0] mm;
    logic [SS_W-1:0] ss;
  } time_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    LOAD  = 2'd2
  } set_state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

endpackage

// File: rtl/hour12_to_24.sv
// Converts a 12h hour (1..12) plus PM flag into a 24h hour (0..23).
// Combinational, zero latency; no handshake. Out-of-range input gives an unspecified result.
module hour12_to_24
  import time_pkg::*;
(
  input  logic [HH_W-1:0] hh12,
  input  logic            pm,
  output logic [HH_W-1:0] hh24
);

  // 12 AM is midnight (0) and 12 PM is noon (12); other hours get +12 in the afternoon.
  always_comb begin
    hh24 = hh12;
    if (hh12 == HH_W'(12)) begin
      hh24 = pm ? HH_W'(12) : '0;
    end else if (pm) begin
      hh24 = hh12 + HH_W'(12);
    end
  end

endmodule

// File: rtl/time_set_12to24.sv
// Validates a user-set 12h/24h time and loads it as 24h {hh,mm,ss} into the time counter.
// Latency: accept N, load_valid from N+2, done N+3; one request in flight, set_ready low until IDLE, load aborts after TIMEOUT_CYC stalled cycles.
module time_set_12to24
  import time_pkg::*;
#(
  parameter int TIME_W      = 17,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mod12_24,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [TIME_W-1:0] set_time,
  input  logic              set_pm,
  output logic              load_valid,
  input  logic              load_ready,
  output logic [TIME_W-1:0] load_time,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  set_state_t       state;
  time_t            cap_time;
  logic             cap_pm;
  logic             cap_mode;
  time_t            load_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [HH_W-1:0]  hh_conv;
  logic [HH_W-1:0]  hh24;
  logic             range_ok;

  hour12_to_24 u_hour12_to_24 (
    .hh12 (cap_time.hh),
    .pm   (cap_pm),
    .hh24 (hh_conv)
  );

  assign hh24 = cap_mode ? hh_conv : cap_time.hh;

  always_comb begin
    range_ok = (cap_time.mm <= MM_W'(59)) && (cap_time.ss <= SS_W'(59));
    if (cap_mode) begin
      range_ok = range_ok && (cap_time.hh != '0) && (cap_time.hh <= HH_W'(12));
    end else begin
      range_ok = range_ok && (cap_time.hh <= HH_W'(23));
    end
  end

  // Held low while reset is asserted so the edit source cannot hand off into a resetting block.
  assign set_ready = (state == IDLE) && reset;
  assign load_time = load_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cap_time   <= '0;
      cap_pm     <= 1'b0;
      cap_mode   <= 1'b0;
      load_q     <= '0;
      load_valid <= 1'b0;
      tmo_cnt    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (set_valid && set_ready) begin
            cap_time <= set_time;
            cap_pm   <= set_pm;
            cap_mode <= mod12_24;
            err_code <= ERR_NONE;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (range_ok) begin
            load_q     <= {hh24, cap_time.mm, cap_time.ss};
            load_valid <= 1'b1;
            tmo_cnt    <= '0;
            state      <= LOAD;
          end else begin
            err      <= 1'b1;
            err_code <= ERR_RANGE;
            state    <= IDLE;
          end
        end
        LOAD: begin
          // A handshake on the limit cycle wins over the abort.
          if (load_ready) begin
            load_valid <= 1'b0;
            done       <= 1'b1;
            tmo_cnt    <= '0;
            state      <= IDLE;
          end else if (TIMEOUT_CYC > 0 && tmo_cnt == TMO_LAST) begin
            load_valid <= 1'b0;
            err        <= 1'b1;
            err_code   <= ERR_TMO;
            tmo_cnt    <= '0;
            state      <= IDLE;
          end else if (TIMEOUT_CYC > 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_12to24.sv
// Directed-vector bench for time_set_12to24 with a short load timeout (8 cycles).
module tb_time_set_12to24;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mod12_24 = 1'b0;
  logic        set_valid = 1'b0;
  logic        set_ready;
  logic [16:0] set_time = '0;
  logic        set_pm = 1'b0;
  logic        load_valid;
  logic        load_ready = 1'b0;
  logic [16:0] load_time;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] last_load = '0;

  always #5 clk = ~clk;

  time_set_12to24 #(
    .TIME_W      (17),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mod12_24   (mod12_24),
    .set_valid  (set_valid),
    .set_ready  (set_ready),
    .set_time   (set_time),
    .set_pm     (set_pm),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_time  (load_time),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at cycle N; returns at N+1 with set_valid dropped.
  task automatic offer(input logic m, input logic [4:0] h, input logic [5:0] mi,
                       input logic [5:0] s, input logic p);
    mod12_24  = m;
    set_time  = {h, mi, s};
    set_pm    = p;
    set_valid = 1'b1;
    check("acc_rdy", 32'(set_ready), 1);
    tick();
    set_valid = 1'b0;
    check("chk_no_lv", 32'(load_valid), 0);
    check("chk_ec_clr", 32'(err_code), 0);
    check("chk_rdy_lo", 32'(set_ready), 0);
  endtask

  task automatic run_ok(input logic m, input logic [4:0] h, input logic [5:0] mi,
                        input logic [5:0] s, input logic p, input logic [4:0] eh,
                        input bit perturb);
    load_ready = 1'b1;
    offer(m, h, mi, s, p);
    if (perturb) begin
      mod12_24 = ~m;
      set_pm   = ~p;
      set_time = 17'h1ffff;
    end
    tick();
    check("lv_n2", 32'(load_valid), 1);
    check("lt_n2", 32'(load_time), 32'({eh, mi, s}));
    last_load = {eh, mi, s};
    tick();
    check("done_n3", 32'(done), 1);
    check("lv_n3", 32'(load_valid), 0);
    check("err_n3", 32'(err), 0);
    check("rdy_n3", 32'(set_ready), 1);
    tick();
    check("done_clr", 32'(done), 0);
  endtask

  task automatic run_bad(input logic m, input logic [4:0] h, input logic [5:0] mi,
                         input logic [5:0] s, input logic p);
    load_ready = 1'b1;
    offer(m, h, mi, s, p);
    tick();
    check("rng_err", 32'(err), 1);
    check("rng_code", 32'(err_code), 1);
    check("rng_no_lv", 32'(load_valid), 0);
    check("rng_keep_lt", 32'(load_time), 32'(last_load));
    check("rng_rdy", 32'(set_ready), 1);
    tick();
    check("rng_err_clr", 32'(err), 0);
    check("rng_code_held", 32'(err_code), 1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rdy", 32'(set_ready), 0);
    check("rst_lv", 32'(load_valid), 0);
    check("rst_lt", 32'(load_time), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_code", 32'(err_code), 0);
    #10;
    reset = 1'b1;
    tick();
    check("post_rst_rdy", 32'(set_ready), 1);

    // Conversions: mode, hh, mm, ss, pm, expected hh
    run_ok(1'b1, 5'd12, 6'd30, 6'd15, 1'b0, 5'd0, 1'b0);
    run_ok(1'b1, 5'd12, 6'd0, 6'd0, 1'b1, 5'd12, 1'b0);
    run_ok(1'b1, 5'd7, 6'd45, 6'd59, 1'b1, 5'd19, 1'b0);
    run_ok(1'b1, 5'd11, 6'd59, 6'd59, 1'b0, 5'd11, 1'b0);
    run_ok(1'b1, 5'd1, 6'd2, 6'd3, 1'b1, 5'd13, 1'b0);
    run_ok(1'b0, 5'd23, 6'd59, 6'd59, 1'b1, 5'd23, 1'b0);
    run_ok(1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 5'd0, 1'b0);

    // Range errors; load_time must keep the last good value
    run_bad(1'b0, 5'd24, 6'd0, 6'd0, 1'b0);
    run_bad(1'b1, 5'd0, 6'd0, 6'd0, 1'b0);
    run_bad(1'b1, 5'd13, 6'd0, 6'd0, 1'b1);
    run_bad(1'b1, 5'd5, 6'd60, 6'd0, 1'b0);
    run_bad(1'b0, 5'd5, 6'd0, 6'd60, 1'b0);

    // Inputs changing after acceptance must not disturb the request
    run_ok(1'b1, 5'd12, 6'd5, 6'd5, 1'b0, 5'd0, 1'b1);

    // Timeout: 12h 3 PM, counter never ready
    load_ready = 1'b0;
    offer(1'b1, 5'd3, 6'd10, 6'd20, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("tmo_lv_hold", 32'(load_valid), 1);
      check("tmo_lt_hold", 32'(load_time), 32'({5'd15, 6'd10, 6'd20}));
      check("tmo_no_err", 32'(err), 0);
    end
    tick();
    check("tmo_lv_drop", 32'(load_valid), 0);
    check("tmo_err", 32'(err), 1);
    check("tmo_code", 32'(err_code), 2);
    check("tmo_rdy", 32'(set_ready), 1);
    check("tmo_keep_lt", 32'(load_time), 32'({5'd15, 6'd10, 6'd20}));
    check("tmo_no_done", 32'(done), 0);
    last_load = {5'd15, 6'd10, 6'd20};
    tick();

    // load_ready arriving on the limit cycle is a success
    load_ready = 1'b0;
    offer(1'b0, 5'd8, 6'd1, 6'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("lim_lv", 32'(load_valid), 1);
    end
    load_ready = 1'b1;
    tick();
    check("lim_done", 32'(done), 1);
    check("lim_no_err", 32'(err), 0);
    check("lim_code", 32'(err_code), 0);
    check("lim_lv_drop", 32'(load_valid), 0);
    tick();

    // Reset during LOAD drops the request with no pulses
    load_ready = 1'b0;
    offer(1'b1, 5'd4, 6'd4, 6'd4, 1'b1);
    tick();
    check("rl_lv", 32'(load_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rl_lv_async", 32'(load_valid), 0);
    check("rl_lt_clr", 32'(load_time), 0);
    check("rl_rdy_lo", 32'(set_ready), 0);
    tick();
    #2;
    reset = 1'b1;
    tick();
    check("rl_no_done", 32'(done), 0);
    check("rl_no_err", 32'(err), 0);
    check("rl_rdy", 32'(set_ready), 1);
    check("rl_lv_idle", 32'(load_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
